// File: rtl/relay_rx_deserializer.sv
// Relay link receiver: recovers start/4-data/stop frames from the raw serial input into nibbles.
// Optional RELAY_RX_GLITCH_FILTER_EN: 2-of-3 majority vote around mid-bit, decisions one cycle later.
module relay_rx_deserializer #(
    parameter int BIT_CYCLES_READER = 16,
    parameter int BIT_CYCLES_TAG    = 32,
    parameter int CNT_W             = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reader_mode,
    input  logic       relay_in,
    output logic [3:0] nibble_out,
    output logic       nibble_valid,
    output logic       frame_error,
    output logic       busy
);

`ifdef RELAY_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    // The first sample lands at mid-bit; the vote needs one extra cycle of history.
    localparam logic [CNT_W-1:0] PER_READER  = CNT_W'(BIT_CYCLES_READER);
    localparam logic [CNT_W-1:0] PER_TAG     = CNT_W'(BIT_CYCLES_TAG);
    localparam logic [CNT_W-1:0] HALF_READER = CNT_W'(BIT_CYCLES_READER / 2 - 1 + FILT);
    localparam logic [CNT_W-1:0] HALF_TAG    = CNT_W'(BIT_CYCLES_TAG / 2 - 1 + FILT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] period_q;
    logic [1:0]       bit_cnt_q;
    logic [3:0]       shift_q;
    logic [3:0]       nibble_q;
    logic             valid_q;
    logic             error_q;
    logic             busy_q;
    logic             start_edge;
    logic             bit_sample;

`ifdef RELAY_RX_GLITCH_FILTER_EN
    logic prev2_q;

    always_ff @(posedge clk) begin
        if (reset) prev2_q <= 1'b0;
        else       prev2_q <= prev_q;
    end

    assign bit_sample = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);
`else
    assign bit_sample = sync2_q;
`endif

    assign start_edge = sync2_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            timer_q   <= '0;
            period_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= 4'h0;
            nibble_q  <= 4'h0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so sync2_q/prev_q below are last cycle's values.
            sync1_q <= relay_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            error_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q  <= S_START;
                        period_q <= reader_mode ? PER_READER : PER_TAG;
                        timer_q  <= reader_mode ? HALF_READER : HALF_TAG;
                        busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (timer_q == '0) begin
                        if (bit_sample) begin
                            state_q   <= S_DATA;
                            timer_q   <= period_q - CNT_W'(1);
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (timer_q == '0) begin
                        shift_q   <= {shift_q[2:0], bit_sample};
                        timer_q   <= period_q - CNT_W'(1);
                        bit_cnt_q <= bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd3) state_q <= S_STOP;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (timer_q == '0) begin
                        if (!bit_sample) begin
                            nibble_q <= shift_q;
                            valid_q  <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign nibble_out   = nibble_q;
    assign nibble_valid = valid_q;
    assign frame_error  = error_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_relay_rx_deserializer.sv
// Bench for relay_rx_deserializer: waveforms built per cycle, expected outputs derived from frame
// timing arithmetic (start edge t0, bit decisions at t0+P/2+kP), compared cycle by cycle.
module tb_relay_rx_deserializer;

    localparam int PR = 16;
    localparam int PT = 32;
`ifdef RELAY_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reader_mode = 1'b1;
    logic       relay_in = 1'b0;
    logic [3:0] nibble_out;
    logic       nibble_valid;
    logic       frame_error;
    logic       busy;

    relay_rx_deserializer dut (
        .clk          (clk),
        .reset        (reset),
        .reader_mode  (reader_mode),
        .relay_in     (relay_in),
        .nibble_out   (nibble_out),
        .nibble_valid (nibble_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit         wave_q[$];
    bit         mode_q[$];
    logic       obs_v[$];
    logic       obs_e[$];
    logic       obs_b[$];
    logic [3:0] obs_n[$];
    bit         exp_v[];
    bit         exp_e[];
    bit         exp_b[];
    logic [3:0] exp_n[];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic void clear_wave();
        wave_q.delete();
        mode_q.delete();
    endfunction

    function automatic void add_idle(input int n, input bit m);
        for (int i = 0; i < n; i++) begin
            wave_q.push_back(1'b0);
            mode_q.push_back(m);
        end
    endfunction

    function automatic int add_frame(input logic [3:0] nib, input bit stop, input bit m);
        int p = m ? PR : PT;
        int r = wave_q.size();
        bit bits[6];
        bits[0] = 1'b1;
        for (int k = 0; k < 4; k++) bits[k+1] = nib[3-k];
        bits[5] = stop;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < p; i++) begin
                wave_q.push_back(bits[k]);
                mode_q.push_back(m);
            end
        return r;
    endfunction

    // Synchronised line value seen by the receiver in cycle c (two-cycle lag, zero after reset).
    function automatic bit s_at(input int c);
        if (c >= 2 && c - 2 < wave_q.size()) return wave_q[c-2];
        return 1'b0;
    endfunction

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic void build_expect();
        int n = wave_q.size();
        int c, t0, p, m, d;
        bit ok, stop, b;
        logic [3:0] data;
        exp_v = new[n];
        exp_e = new[n];
        exp_b = new[n];
        exp_n = new[n];
        for (int i = 0; i < n; i++) begin
            exp_v[i] = 1'b0;
            exp_e[i] = 1'b0;
            exp_b[i] = 1'b0;
            exp_n[i] = 4'h0;
        end
        c = 1;
        while (c < n) begin
            if (s_at(c) && !s_at(c - 1)) begin
                t0 = c;
                p = mode_q[t0] ? PR : PT;
                ok = 1'b1;
                stop = 1'b0;
                data = 4'h0;
                d = t0;
                for (int k = 0; k < 6; k++) begin
                    m = t0 + p / 2 + k * p;
                    d = m + FILT;
                    b = (FILT == 1) ? maj3(s_at(m - 1), s_at(m), s_at(m + 1)) : s_at(m);
                    if (k == 0 && !b) begin
                        ok = 1'b0;
                        break;
                    end
                    if (k >= 1 && k <= 4) data = {data[2:0], b};
                    if (k == 5) stop = b;
                end
                for (int i = t0 + 1; i <= d && i < n; i++) exp_b[i] = 1'b1;
                if (ok && d + 1 < n) begin
                    if (!stop) begin
                        exp_v[d+1] = 1'b1;
                        for (int i = d + 1; i < n; i++) exp_n[i] = data;
                    end else begin
                        exp_e[d+1] = 1'b1;
                    end
                end
                c = d + 1;
            end else begin
                c++;
            end
        end
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        relay_in = 1'b0;
        reader_mode = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_nibble", nibble_out, 4'h0);
        check("rst_valid", nibble_valid, 1'b0);
        check("rst_error", frame_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
    endtask

    task automatic play();
        obs_v.delete();
        obs_e.delete();
        obs_b.delete();
        obs_n.delete();
        for (int c = 0; c < wave_q.size(); c++) begin
            @(posedge clk);
            #1;
            obs_v.push_back(nibble_valid);
            obs_e.push_back(frame_error);
            obs_b.push_back(busy);
            obs_n.push_back(nibble_out);
            relay_in = wave_q[c];
            reader_mode = mode_q[c];
        end
    endtask

    task automatic run_segment(input bit with_reset);
        if (with_reset) do_reset();
        build_expect();
        play();
        for (int c = 0; c < wave_q.size(); c++) begin
            check($sformatf("valid[%0d]", c), obs_v[c], exp_v[c]);
            check($sformatf("error[%0d]", c), obs_e[c], exp_e[c]);
            check($sformatf("busy[%0d]", c), obs_b[c], exp_b[c]);
            check($sformatf("nibble[%0d]", c), obs_n[c], exp_n[c]);
        end
    endtask

    function automatic int first_pulse(input int from);
        for (int i = (from < 0 ? 0 : from); i < obs_v.size(); i++)
            if (obs_v[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_v();
        int n = 0;
        foreach (obs_v[i]) if (obs_v[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_e();
        int n = 0;
        foreach (obs_e[i]) if (obs_e[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, r2, p1, p2, lat;
        bit m, stop;
        lat = 91 + FILT;

        // Nibble C at reader rate: absolute latency and busy window.
        clear_wave();
        add_idle(10, 1'b1);
        r = add_frame(4'hC, 1'b0, 1'b1);
        add_idle(150, 1'b1);
        run_segment(1'b1);
        check("lat_C", first_pulse(0), r + lat);
        check("nib_C", obs_n[r+lat], 4'hC);
        check("cnt_C", count_v(), 1);
        check("busy_before", obs_b[r+2], 1'b0);
        check("busy_first", obs_b[r+3], 1'b1);
        check("busy_last", obs_b[r+lat-1], 1'b1);
        check("busy_fall", obs_b[r+lat], 1'b0);

        // Back-to-back tag-rate frames, single stop bit each.
        clear_wave();
        add_idle(10, 1'b0);
        r = add_frame(4'h5, 1'b0, 1'b0);
        void'(add_frame(4'hA, 1'b0, 1'b0));
        add_idle(250, 1'b0);
        run_segment(1'b1);
        p1 = first_pulse(0);
        p2 = first_pulse(p1 + 1);
        check("b2b_lat", p1, r + 2 + PT / 2 + 5 * PT + 1 + FILT);
        check("b2b_gap", p2 - p1, 6 * PT);
        check("b2b_nib1", (p1 >= 0) ? obs_n[p1] : 4'hx, 4'h5);
        check("b2b_nib2", (p2 >= 0) ? obs_n[p2] : 4'hx, 4'hA);

        // Four-cycle glitch on an idle line is a false start.
        clear_wave();
        add_idle(10, 1'b1);
        r = wave_q.size();
        for (int i = 0; i < 4; i++) begin
            wave_q.push_back(1'b1);
            mode_q.push_back(1'b1);
        end
        add_idle(60, 1'b1);
        run_segment(1'b1);
        check("glitch_busy", obs_b[r+3], 1'b1);
        check("glitch_valid", count_v(), 0);
        check("glitch_error", count_e(), 0);
        check("glitch_idle", obs_b[obs_b.size()-1], 1'b0);

        // Good frame then bad stop bit: error pulse, nibble held.
        clear_wave();
        add_idle(10, 1'b1);
        void'(add_frame(4'h7, 1'b0, 1'b1));
        add_idle(5, 1'b1);
        r2 = add_frame(4'h3, 1'b1, 1'b1);
        add_idle(100, 1'b1);
        run_segment(1'b1);
        check("ferr_valid_cnt", count_v(), 1);
        check("ferr_error_cnt", count_e(), 1);
        check("ferr_error_at", obs_e[r2+lat], 1'b1);
        check("ferr_nib_hold", obs_n[obs_n.size()-1], 4'h7);

        // Reset forty cycles into a frame, then a clean frame F.
        clear_wave();
        add_idle(10, 1'b1);
        void'(add_frame(4'h9, 1'b0, 1'b1));
        add_idle(20, 1'b1);
        run_segment(1'b1);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            reader_mode = 1'b1;
            relay_in = (c < 16) ? 1'b1 : (c < 32) ? 1'b1 : 1'b0;
        end
        @(posedge clk);
        #1;
        check("mid_busy", busy, 1'b1);
        check("mid_nib_before", nibble_out, 4'h9);
        reset = 1'b1;
        relay_in = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_nibble", nibble_out, 4'h0);
        check("mid_rst_valid", nibble_valid, 1'b0);
        check("mid_rst_error", frame_error, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        reset = 1'b0;
        clear_wave();
        add_idle(10, 1'b1);
        r = add_frame(4'hF, 1'b0, 1'b1);
        add_idle(150, 1'b1);
        run_segment(1'b0);
        check("post_rst_lat", first_pulse(0), r + lat);
        check("post_rst_nib", obs_n[obs_n.size()-1], 4'hF);

        // Mode flips mid-frame: the frame keeps the rate it started with.
        clear_wave();
        add_idle(10, 1'b1);
        r = add_frame(4'h6, 1'b0, 1'b1);
        add_idle(150, 1'b0);
        for (int i = r + 20; i < mode_q.size(); i++) mode_q[i] = 1'b0;
        run_segment(1'b1);
        check("toggle_lat", first_pulse(0), r + lat);
        check("toggle_nib", obs_n[obs_n.size()-1], 4'h6);

        // Random frames, modes, gaps, stop errors and single-cycle glitches.
        for (int seg = 0; seg < 6; seg++) begin
            clear_wave();
            add_idle(5, 1'b1);
            for (int f = 0; f < 8; f++) begin
                m = 1'($urandom_range(0, 1));
                stop = ($urandom_range(0, 7) == 0);
                add_idle($urandom_range(0, 12), m);
                void'(add_frame(4'($urandom_range(0, 15)), stop, m));
            end
            for (int g = 0; g < 3; g++) begin
                int pos = $urandom_range(5, wave_q.size() - 1);
                wave_q[pos] = ~wave_q[pos];
            end
            add_idle(250, 1'b1);
            run_segment(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
